// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 integer multiply/divide unit (RV32M/RV64M funct3 set).
// The execute stage issues requests through a valid/ready handshake and takes the
// result through a second valid/ready handshake.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one combinational
// multiplier and complete on the accept edge; divides stay iterative.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high
// CALC  | one shift-add / restoring shift-subtract iteration per cycle
// NEG   | select result word, apply result sign, register into o_result
// DONE  | o_valid high, o_result held until i_ready
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;

  logic [2:0]        op_q;
  logic              neg_res;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] prod;
  logic [CNT_W-1:0]  cnt;

  logic              op1_signed;
  logic              op2_signed;
  logic              sgn1;
  logic              sgn2;
  logic              neg_in;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;

  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic              fast_path;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_step;

  logic [2*XLEN-1:0] prod_neg;
  logic [2*XLEN-1:0] mul_sel;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   div_fin;
  logic [XLEN-1:0]   res_nxt;

  // Which operands of the incoming op are treated as signed
  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (i_op)
      OP_MULH, OP_DIV, OP_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      OP_MULHSU: op1_signed = 1'b1;
      default: ;
    endcase
  end

  assign sgn1 = op1_signed & i_op1[XLEN-1];
  assign sgn2 = op2_signed & i_op2[XLEN-1];
  assign mag1 = sgn1 ? -i_op1 : i_op1;
  assign mag2 = sgn2 ? -i_op2 : i_op2;

  // MUL low word is identical for signed and unsigned operands, so it never negates.
  // Remainder takes the dividend's sign only.
  assign neg_in = (i_op == OP_REM) ? sgn1 :
                  (i_op == OP_MUL) ? 1'b0 : (sgn1 ^ sgn2);

  assign div_zero = i_op[2] && (i_op2 == '0);
  assign div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_op1 == MOST_NEG) && (i_op2 == '1);
  assign special  = div_zero | div_ovf;

  // Special-case results; i_op[1] distinguishes remainder from quotient
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = i_op[1] ? i_op1 : '1;
    else          special_res = i_op[1] ? '0 : i_op1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fm_a;
  logic [2*XLEN-1:0] fm_b;
  logic [2*XLEN-1:0] fm_p;

  // Sign-extending to 2*XLEN makes a plain unsigned multiply exact for every mix
  assign fm_a      = {{XLEN{sgn1}}, i_op1};
  assign fm_b      = {{XLEN{sgn2}}, i_op2};
  assign fm_p      = fm_a * fm_b;
  assign fast_path = special | ~i_op[2];
  assign fast_res  = special ? special_res :
                     (i_op == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
`else
  assign fast_path = special;
  assign fast_res  = special_res;
`endif

  // Multiply: prod holds {partial sum, remaining multiplier bits}, shifting right
  assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, opb};
  assign mul_step = prod[0] ? {mul_sum, prod[XLEN-1:1]}
                            : {1'b0, prod[2*XLEN-1:1]};

  // Divide: prod holds {remainder, dividend/quotient}, shifting left
  assign div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  prod[XLEN-2:0], 1'b1};

  // High-word multiply results need the full 2*XLEN negation, not just the top word
  assign prod_neg = -prod;
  assign mul_sel  = neg_res ? prod_neg : prod;
  assign div_sel  = op_q[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  assign div_fin  = neg_res ? -div_sel : div_sel;
  assign res_nxt  = op_q[2] ? div_fin :
                    (op_q == OP_MUL) ? mul_sel[XLEN-1:0] : mul_sel[2*XLEN-1:XLEN];

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; flush overrides everything, including an accept
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    o_ready   = (state == IDLE);
    o_valid   = (state == DONE);
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          accept    = 1'b1;
          state_nxt = fast_path ? DONE : CALC;
        end
        CALC: if (cnt == CNT_ONE) state_nxt = NEG;
        NEG:  state_nxt = DONE;
        DONE: if (i_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign o_busy = ~o_ready;

  // Operand capture, iteration datapath and result register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= '0;
      neg_res  <= 1'b0;
      opb      <= '0;
      prod     <= '0;
      cnt      <= '0;
      o_result <= '0;
    end else if (accept) begin
      op_q    <= i_op;
      neg_res <= neg_in;
      cnt     <= CNT_INIT;
      opb     <= i_op[2] ? mag2 : mag1;
      prod    <= {{XLEN{1'b0}}, (i_op[2] ? mag1 : mag2)};
      if (fast_path) o_result <= fast_res;
    end else if (state == CALC) begin
      prod <= op_q[2] ? div_step : mul_step;
      cnt  <= cnt - CNT_ONE;
    end else if ((state == NEG) && !i_flush) begin
      o_result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at XLEN=32.
// Build with MULDIV_FAST_MUL_EN defined to expect single-cycle multiplies.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;
  localparam int SPC_LAT = 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  int              n_tests;
  int              n_fail;
  logic [XLEN-1:0] sb[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_op1   (i_op1),
    .i_op2   (i_op2),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; caller must be in IDLE
  task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    i_valid = 1'b1;
    i_op    = op;
    i_op1   = a;
    i_op2   = b;
    tick();
    i_valid = 1'b0;
  endtask

  // Count cycles from the accept cycle (=1) until o_valid, then score the result
  task automatic get_result(input string tag, input int lat);
    int n;
    logic [XLEN-1:0] exp;
    n = 1;
    while (!o_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "/lat"}, n, lat);
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      chk({tag, "/res"}, o_result, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    chk({tag, "/rdy"}, o_ready, 1);
    sb.push_back(exp);
    send(op, a, b);
    get_result(tag, lat);
    tick();
    chk({tag, "/idle"}, {o_ready, o_valid, o_busy}, 3'b100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [XLEN-1:0] exp;
    int n;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_op    = '0;
    i_op1   = '0;
    i_op2   = '0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset/ready",  o_ready,  1);
    chk("reset/valid",  o_valid,  0);
    chk("reset/busy",   o_busy,   0);
    chk("reset/result", o_result, 0);

    run_vec("mul",    OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_vec("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_vec("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_vec("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT);
    run_vec("div",    OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
    run_vec("rem",    OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
    run_vec("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT);
    run_vec("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);
    run_vec("divu0",  OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
    run_vec("rem0",   OP_REM,    32'd5,         32'd0,         32'd5,         SPC_LAT);
    run_vec("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run_vec("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

    // Backpressure: result held while i_ready is low, new requests ignored
    i_ready = 1'b0;
    sb.push_back(32'd14);
    send(OP_DIVU, 32'd100, 32'd7);
    n = 1;
    while (!o_valid && n < 200) begin
      tick();
      n++;
    end
    chk("bp/lat", n, DIV_LAT);
    i_valid = 1'b1;
    i_op    = OP_MUL;
    i_op1   = 32'd9;
    i_op2   = 32'd9;
    for (int i = 0; i < 10; i++) begin
      chk("bp/valid",  o_valid,  1);
      chk("bp/result", o_result, 32'd14);
      chk("bp/ready",  o_ready,  0);
      tick();
    end
    i_valid = 1'b0;
    if (sb.size() == 0) begin
      chk("bp/sb_empty", 1, 0);
    end else begin
      exp = sb.pop_front();
      chk("bp/sb", o_result, exp);
    end
    i_ready = 1'b1;
    tick();
    chk("bp/idle", {o_ready, o_valid}, 2'b10);
    tick();
    chk("bp/no_accept", {o_ready, o_valid}, 2'b10);

    // Flush during the fifth CALC cycle, then a fresh multiply
    send(OP_DIVU, 32'd1000, 32'd3);
    repeat (4) tick();
    chk("fl/busy", o_busy, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("fl/state", {o_ready, o_valid}, 2'b10);
    chk("fl/hold",  o_result, 32'd14);
    run_vec("fl/mul", OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

    // Asynchronous reset in the middle of a divide
    send(OP_DIV, 32'hFFFF_FC18, 32'd7);
    repeat (10) tick();
    chk("rst/busy_before", o_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst/valid",  o_valid,  0);
    chk("rst/ready",  o_ready,  1);
    chk("rst/result", o_result, 0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      tick();
      if (o_valid) seen = 1'b1;
    end
    chk("rst/no_valid", seen, 0);
    chk("rst/sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
